// File: rtl/mag_block_stats_if.sv
// Sample and result handshakes between the magnitude stage, the block
// statistics unit and its consumer.
interface mag_block_stats_if #(
    parameter int LOG2_N = 3
);
    logic [7:0]      mag_in;
    logic            mag_valid;
    logic            mag_ready;
    logic            res_valid;
    logic            res_ready;
    logic [7:0]      mean_out;
    logic [7:0]      max_out;
    logic [7:0]      min_out;
    logic [LOG2_N:0] over_cnt;

    modport master (
        output mag_in, mag_valid, res_ready,
        input  mag_ready, res_valid,
        input  mean_out, max_out, min_out, over_cnt
    );

    modport slave (
        input  mag_in, mag_valid, res_ready,
        output mag_ready, res_valid,
        output mean_out, max_out, min_out, over_cnt
    );
endinterface

// File: rtl/mag_block_stats.sv
// Per-block mean/max/min/over-threshold statistics of 8-bit magnitudes,
// with a single held result and full backpressure on the sample side.
module mag_block_stats #(
    parameter int LOG2_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [7:0]       thresh,
    mag_block_stats_if.slave bus
);
    localparam int N  = 1 << LOG2_N;
    localparam int SW = 8 + LOG2_N;
    localparam int CW = LOG2_N + 1;

    typedef enum logic {
        ACCUM,
        PRESENT
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]     sum_q, sum_d;
    logic [7:0]        max_q, max_d;
    logic [7:0]        min_q, min_d;
    logic [CW-1:0]     over_q, over_d;
    logic [LOG2_N-1:0] cnt_q;

    logic [7:0]        mean_r, max_r, min_r;
    logic [CW-1:0]     over_r;

    logic accept;
    logic xfer;
    logic last;

    assign bus.mag_ready = ena && !rst && (state_q == ACCUM);
    assign bus.res_valid = (state_q == PRESENT);

    assign accept = bus.mag_valid && bus.mag_ready;
    assign xfer   = bus.res_valid && bus.res_ready && ena;
    assign last   = (cnt_q == LOG2_N'(N - 1));

    // Running values including the sample offered this cycle
    always_comb begin
        sum_d  = sum_q + SW'(bus.mag_in);
        max_d  = (bus.mag_in > max_q) ? bus.mag_in : max_q;
        min_d  = (bus.mag_in < min_q) ? bus.mag_in : min_q;
        over_d = over_q + CW'(bus.mag_in > thresh);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last) state_d = PRESENT;
            PRESENT: if (xfer) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            max_q  <= 8'h00;
            min_q  <= 8'hFF;
            over_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            if (last) begin
                sum_q  <= '0;
                max_q  <= 8'h00;
                min_q  <= 8'hFF;
                over_q <= '0;
                cnt_q  <= '0;
            end else begin
                sum_q  <= sum_d;
                max_q  <= max_d;
                min_q  <= min_d;
                over_q <= over_d;
                cnt_q  <= cnt_q + LOG2_N'(1);
            end
        end
    end

    // Result registers move only when a block completes
    always_ff @(posedge clk) begin
        if (rst) begin
            mean_r <= '0;
            max_r  <= '0;
            min_r  <= '0;
            over_r <= '0;
        end else if (accept && last) begin
            mean_r <= sum_d[SW-1:LOG2_N];
            max_r  <= max_d;
            min_r  <= min_d;
            over_r <= over_d;
        end
    end

    assign bus.mean_out = mean_r;
    assign bus.max_out  = max_r;
    assign bus.min_out  = min_r;
    assign bus.over_cnt = over_r;
endmodule
